// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate multiplier front-end.
//   ha_mode_e : per-column reduction mode (eliminate, OR-sum, exact half adder)
//   col_mode  : maps a column's absolute weight and the two thresholds to its mode
package approx_mul_pkg;

  typedef enum logic [1:0] {
    HA_ELIM,
    HA_OR,
    HA_EXACT
  } ha_mode_e;

  // Columns below elim are dropped. Columns in [elim, or_th) are OR-summed.
  // Everything at or above max(elim, or_th) is exact.
  function automatic ha_mode_e col_mode(input int w, input int elim, input int or_th);
    if (w < elim) return HA_ELIM;
    if (w < or_th) return HA_OR;
    return HA_EXACT;
  endfunction

endpackage

// File: rtl/approx_ha_cell.sv
// One configurable half-adder cell of the partial-product reduction array.
//   a, b  : partial-product bits of equal absolute weight
//   mode  : HA_ELIM -> sum = carry = 0; HA_OR -> sum = a|b, carry = 0;
//           HA_EXACT -> {carry, sum} = a + b
//   sum   : result bit at the column weight
//   carry : result bit at the column weight + 1
module approx_ha_cell
  import approx_mul_pkg::*;
(
  input  logic     a,
  input  logic     b,
  input  ha_mode_e mode,
  output logic     sum,
  output logic     carry
);

  always_comb begin
    sum   = 1'b0;
    carry = 1'b0;
    case (mode)
      HA_OR: sum = a | b;
      HA_EXACT: begin
        sum   = a ^ b;
        carry = a & b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/approx_ha_array_pipe.sv
// Pipelined partial-product + half-adder array front-end for unsigned WxW
// approximate multipliers. Row pair r (pp rows 2r and 2r+1) is reduced by
// one row of configurable HA cells into a sum row ha_t and a carry row ha_b.
// Thresholds are captured together with the operands, so every transaction
// carries its own configuration.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake
//   x, y                : unsigned operands
//   cfg_elim, cfg_or    : column-mode thresholds (absolute weight)
//   out_valid, out_ready: result handshake
//   ha_b                : carry rows, row r at [r*(W-1) +: W-1], bit k weight 2r+k+2
//   ha_t                : sum rows,   row r at [r*(W+1) +: W+1], bit k weight 2r+k
module approx_ha_array_pipe
  import approx_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int CFG_W = $clog2(2 * W)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               x,
  input  logic [W-1:0]               y,
  input  logic [CFG_W-1:0]           cfg_elim,
  input  logic [CFG_W-1:0]           cfg_or,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(W/2)*(W-1)-1:0]     ha_b,
  output logic [(W/2)*(W+1)-1:0]     ha_t
);

  localparam int NROWS = W / 2;

  logic [W-1:0]              x_p1;
  logic [W-1:0]              y_p1;
  logic [CFG_W-1:0]          elim_p1;
  logic [CFG_W-1:0]          or_p1;
  logic                      vld_p1;
  logic                      vld_p2;
  logic                      s2_adv;
  logic [NROWS*(W-1)-1:0]    ha_b_nxt;
  logic [NROWS*(W+1)-1:0]    ha_t_nxt;

  // S2 frees up when empty or when downstream takes the result; S1 moves
  // into S2 on the same condition, so a full pipe still accepts every cycle
  // while out_ready is high.
  assign s2_adv    = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || s2_adv;
  assign out_valid = vld_p2;

  // ---- S1: operand and configuration capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      x_p1    <= '0;
      y_p1    <= '0;
      elim_p1 <= '0;
      or_p1   <= '0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        x_p1    <= x;
        y_p1    <= y;
        elim_p1 <= cfg_elim;
        or_p1   <= cfg_or;
      end
    end
  end

  // Combinational HA array between S1 and S2.
  for (genvar r = 0; r < NROWS; r++) begin : g_row
    logic [W-2:0] sum_c;
    logic [W-2:0] carry_c;
    logic         t0;

    // Cell c (1..W-1) pairs pp[2r][c] with pp[2r+1][c-1], both at weight 2r+c.
    for (genvar c = 1; c < W; c++) begin : g_col
      approx_ha_cell u_cell (
        .a     (x_p1[2*r] & y_p1[c]),
        .b     (x_p1[2*r+1] & y_p1[c-1]),
        .mode  (col_mode(2*r + c, int'(elim_p1), int'(or_p1))),
        .sum   (sum_c[c-1]),
        .carry (carry_c[c-1])
      );
    end

    // The lone low bit of the even row is only ever kept or dropped.
    assign t0 = (2*r < int'(elim_p1)) ? 1'b0 : (x_p1[2*r] & y_p1[0]);

    assign ha_t_nxt[r*(W+1) +: W+1] = {carry_c[W-2], sum_c, t0};
    // Top bit of the odd row has no partner and passes through unchanged.
    assign ha_b_nxt[r*(W-1) +: W-1] = {x_p1[2*r+1] & y_p1[W-1], carry_c[W-3:0]};
  end

  // ---- S2: registered array outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      ha_b   <= '0;
      ha_t   <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        ha_b <= ha_b_nxt;
        ha_t <= ha_t_nxt;
      end
    end
  end

endmodule

// File: tb/tb_approx_ha_array_pipe.sv
module tb_approx_ha_array_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [3:0]  cfg_elim;
  logic [3:0]  cfg_or;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] ha_b;
  logic [35:0] ha_t;

  approx_ha_array_pipe #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cfg_elim  (cfg_elim),
    .cfg_or    (cfg_or),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ha_b      (ha_b),
    .ha_t      (ha_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [7:0]  xv;
    logic [7:0]  yv;
    bit          exact;
  } sb_t;

  sb_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Values captured by step() just before the active edge.
  logic [63:0] obs_v;
  logic        ov_s;

  localparam logic [63:0] FF_EXACT = {{4{7'h7F}}, {4{9'h101}}};

  // Reference model written from the column rules: {ha_b, ha_t}.
  function automatic logic [63:0] model(input logic [7:0] xv, input logic [7:0] yv,
                                        input int e, input int o);
    logic [27:0] bb;
    logic [35:0] tt;
    logic a, b, s, cy;
    int w;
    bb = '0;
    tt = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 1; c < 8; c++) begin
        a = xv[2*r] & yv[c];
        b = xv[2*r+1] & yv[c-1];
        w = 2*r + c;
        if (w < e) begin s = 1'b0; cy = 1'b0; end
        else if (w < o) begin s = a | b; cy = 1'b0; end
        else begin s = a ^ b; cy = a & b; end
        tt[r*9 + c] = s;
        if (c == 7) tt[r*9 + 8] = cy;
        else bb[r*7 + c - 1] = cy;
      end
      tt[r*9] = (2*r < e) ? 1'b0 : (xv[2*r] & yv[0]);
      bb[r*7 + 6] = xv[2*r+1] & yv[7];
    end
    return {bb, tt};
  endfunction

  function automatic int recon(input logic [63:0] v);
    int s;
    s = 0;
    for (int r = 0; r < 4; r++)
      s += (int'(v[r*9 +: 9]) + (int'(v[36 + r*7 +: 7]) << 2)) << (2*r);
    return s;
  endfunction

  // Called at a negedge with inputs already driven; samples the handshakes
  // 1 time unit before the rising edge and returns at the following negedge.
  task automatic step(output bit inf, output bit outf);
    #4;
    inf   = in_valid && in_ready;
    outf  = out_valid && out_ready;
    ov_s  = out_valid;
    obs_v = {ha_b, ha_t};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp();
    sb_t s;
    s.res   = model(x, y, int'(cfg_elim), int'(cfg_or));
    s.xv    = x;
    s.yv    = y;
    s.exact = (cfg_elim == 4'd0) && (cfg_or <= 4'd1);
    sb.push_back(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cfg_elim = '0; cfg_or = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || ha_b !== '0 || ha_t !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ov=%b b=%h t=%h, need 0/0/0", out_valid, ha_b, ha_t);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b ov=%b, need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_exact_ff();
    bit inf, outf;
    int lat;
    x = 8'hFF; y = 8'hFF; cfg_elim = 4'd0; cfg_or = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    step(inf, outf);
    in_valid = 1'b0;
    vectors++;
    if (!inf) begin miscompares++; $display("FAIL exact_accept: got 0, need 1"); end
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      step(inf, outf);
      if (outf) lat = i;
    end
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL exact_latency: got %0d, need 2", lat); end
    vectors++;
    if (obs_v !== FF_EXACT) begin
      miscompares++;
      $display("FAIL exact_ff_rows: got %h, need %h", obs_v, FF_EXACT);
    end
    vectors++;
    if (recon(obs_v) != 65025) begin
      miscompares++;
      $display("FAIL exact_ff_sum: got %0d, need 65025", recon(obs_v));
    end
  endtask

  task automatic test_cfg_small();
    bit inf, outf;
    bit seen;
    x = 8'h03; y = 8'h03; cfg_elim = 4'd2; cfg_or = 4'd4; in_valid = 1'b1; out_ready = 1'b1;
    step(inf, outf);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(inf, outf);
      if (outf) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL small_timeout: no output"); end
    vectors++;
    if (obs_v !== {28'h0, 27'h0, 9'h004}) begin
      miscompares++;
      $display("FAIL small_rows: got %h, need %h", obs_v, {28'h0, 27'h0, 9'h004});
    end
    vectors++;
    if (recon(obs_v) != 4) begin
      miscompares++;
      $display("FAIL small_sum: got %0d, need 4", recon(obs_v));
    end
  endtask

  task automatic test_random();
    bit inf, outf;
    int sent, cyc;
    sb_t e;
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
      if (!in_valid || inf) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 9) < 8);
        x = 8'($urandom);
        y = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          cfg_elim = 4'd0; cfg_or = 4'd0;
        end else begin
          cfg_elim = 4'($urandom_range(0, 15));
          cfg_or   = 4'($urandom_range(0, 15));
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step(inf, outf);
      cyc++;
      if (outf) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra: got %h, need no output", obs_v);
        end else begin
          e = sb.pop_front();
          if (obs_v !== e.res) begin
            miscompares++;
            $display("FAIL rand_result: x=%h y=%h got %h, need %h", e.xv, e.yv, obs_v, e.res);
          end
          if (e.exact) begin
            vectors++;
            if (recon(obs_v) != int'(e.xv) * int'(e.yv)) begin
              miscompares++;
              $display("FAIL rand_exact_sum: got %0d, need %0d", recon(obs_v), int'(e.xv) * int'(e.yv));
            end
          end
        end
      end
      if (inf) begin
        push_exp();
        sent++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (sent != 10000 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: got sent=%0d pending=%0d, need 10000/0", sent, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit inf, outf;
    int idx, outs;
    logic [7:0] ops [3];
    logic [63:0] held;
    bit have;
    sb_t e;
    ops[0] = 8'h5A; ops[1] = 8'hC3; ops[2] = 8'h81;
    cfg_elim = 4'd3; cfg_or = 4'd7;
    out_ready = 1'b0;
    idx = 0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (idx < 3);
      x = ops[idx % 3]; y = ~ops[idx % 3];
      step(inf, outf);
      if (ov_s) begin
        if (have) begin
          vectors++;
          if (obs_v !== held) begin
            miscompares++;
            $display("FAIL bp_stable: got %h, need %h", obs_v, held);
          end
        end else begin
          held = obs_v;
          have = 1'b1;
        end
      end
      if (inf) begin push_exp(); idx++; end
    end
    vectors++;
    if (idx != 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d in_ready=%b, need 2/0", idx, in_ready);
    end
    out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 20 && outs < 3; i++) begin
      in_valid = (idx < 3);
      x = ops[idx % 3]; y = ~ops[idx % 3];
      step(inf, outf);
      if (outf) begin
        outs++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: got %h, need no output", obs_v);
        end else begin
          e = sb.pop_front();
          if (obs_v !== e.res) begin
            miscompares++;
            $display("FAIL bp_order: x=%h got %h, need %h", e.xv, obs_v, e.res);
          end
        end
      end
      if (inf) begin push_exp(); idx++; end
    end
    in_valid = 1'b0;
    vectors++;
    if (outs != 3) begin miscompares++; $display("FAIL bp_count: got %0d, need 3", outs); end
  endtask

  task automatic test_cfg_change();
    bit inf, outf;
    int outs;
    logic [63:0] r [2];
    x = 8'hFF; y = 8'hFF; cfg_elim = 4'd0; cfg_or = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    outs = 0;
    r[0] = '0; r[1] = '0;
    step(inf, outf);
    cfg_elim = 4'd6; cfg_or = 4'd10;
    for (int i = 0; i < 8 && outs < 2; i++) begin
      step(inf, outf);
      in_valid = 1'b0;
      if (outf) begin r[outs] = obs_v; outs++; end
    end
    vectors++;
    if (outs != 2) begin miscompares++; $display("FAIL cfgchg_count: got %0d, need 2", outs); end
    vectors++;
    if (r[0] !== FF_EXACT) begin
      miscompares++;
      $display("FAIL cfgchg_first: got %h, need %h", r[0], FF_EXACT);
    end
    vectors++;
    if (r[1] !== model(8'hFF, 8'hFF, 6, 10)) begin
      miscompares++;
      $display("FAIL cfgchg_second: got %h, need %h", r[1], model(8'hFF, 8'hFF, 6, 10));
    end
  endtask

  task automatic test_reset_mid();
    bit inf, outf;
    int seen;
    x = 8'hA7; y = 8'h3C; cfg_elim = 4'd0; cfg_or = 4'd0;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) step(inf, outf);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_setup: got ov=%b, need 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || ha_b !== '0 || ha_t !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got ov=%b b=%h t=%h, need 0/0/0", out_valid, ha_b, ha_t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(inf, outf);
      if (ov_s) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rstmid_stale: got %0d outputs, need 0", seen);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exact_ff();
    test_cfg_small();
    test_random();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
